pushbutton_debounce_bank: RTL and testbench
===========================================

Name: pushbutton_debounce_bank

Overview:
Parametrised, multi-channel successor to the per-button debouncers on the DE2 board top level. Each of NUM_BTN raw pushbutton inputs is synchronised to clk_27 and debounced with a programmable stable-time. Each channel produces a clean level, a one-cycle press pulse, a one-cycle release pulse and an optional auto-repeat press pulse. Sits between the board pins and the processor's Clock, Display_Enable and PC_Reset inputs.

Parameters:
NUM_BTN, 4, number of independent button channels
STABLE_CYCLES, 270000, consecutive stable clk_27 cycles needed to accept a level change (10 ms at 27 MHz); must be >= 2
REPEAT_DELAY, 13500000, cycles held before the first auto-repeat pulse (0.5 s)
REPEAT_PERIOD, 2700000, cycles between subsequent auto-repeat pulses (0.1 s); must be >= 2
BTN_ACTIVE_LOW, 1, 1 = a pressed button reads 0 on btn_raw (DE2 KEY behaviour)

Ports:
clk_27  input  1  system clock; all logic is on its rising edge
reset_L  input  1  synchronous active-low reset
btn_raw  input  NUM_BTN  asynchronous raw button pins
repeat_en  input  NUM_BTN  per-channel auto-repeat enable, synchronous to clk_27
btn_state  output  NUM_BTN  debounced level, 1 = pressed, polarity-normalised
btn_press  output  NUM_BTN  1-cycle pulse on accepted press and on each auto-repeat
btn_release  output  NUM_BTN  1-cycle pulse on accepted release

Behaviour:
- Reset (reset_L low at a clk_27 edge): synchroniser flops load the released level; btn_state, btn_press, btn_release = 0; all counters = 0. Reset mid-debounce or mid-repeat discards progress, with no pulse emitted.
- Synchroniser: 2-FF per channel; the output is polarity-normalised (inverted when BTN_ACTIVE_LOW=1) so that sync = 1 means pressed.
- Debounce counter (width $clog2(STABLE_CYCLES+1)):
  - Any cycle with sync == btn_state clears the counter.
  - While sync != btn_state, the counter increments.
  - On the cycle the counter would reach STABLE_CYCLES, btn_state toggles and the counter clears.
  - Latency from the first raw sample of a clean change to btn_state toggling: 2 + STABLE_CYCLES cycles. A glitch shorter than STABLE_CYCLES cycles produces no change.
- Pulses are registered and asserted in the same cycle btn_state toggles:
  - btn_press on a 0->1 toggle.
  - btn_release on a 1->0 toggle.
  - A press and a release can never both be high on one channel in one cycle.
- Per-channel FSM: IDLE, PRESSED, REPEAT.
  - IDLE -> PRESSED when btn_state rises; the repeat counter clears.
  - PRESSED: if repeat_en = 1, the repeat counter increments. When it reaches REPEAT_DELAY, emit btn_press, clear the counter and go to REPEAT. If repeat_en = 0, the counter is held at 0.
  - REPEAT: the counter increments. At REPEAT_PERIOD, emit btn_press and clear the counter. If repeat_en drops, clear the counter and go to PRESSED.
  - Any state -> IDLE when btn_state falls; the repeat counter clears and no repeat pulse is issued in that cycle.
- Repeat counter width: $clog2(max(REPEAT_DELAY, REPEAT_PERIOD)+1). It never wraps, because it clears on match.
- Button held through reset release: after 2 + STABLE_CYCLES cycles the channel reports an ordinary press.
- Channels are fully independent. Simultaneous events on different channels are all reported in the same cycle.

Decomposition:
- Shared package: the FSM state enum {IDLE, PRESSED, REPEAT} and a clog2-based width function.
- Sub-module debounce_channel holds the synchroniser, debounce counter, FSM and repeat counter for one channel. It is instantiated NUM_BTN times in a generate loop.
- The top level only performs the polarity/parameter fan-out.

Test Plan:
All scenarios use NUM_BTN=4, STABLE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3, BTN_ACTIVE_LOW=1.
1. Reset, then drive btn_raw[0] 1->0 and hold -> btn_state[0] and btn_press[0] rise exactly 6 cycles after the first low sample; btn_press[0] is high for 1 cycle; other channels stay 0.
2. Bounce btn_raw[1] low for 3 cycles, high for 1, repeating for 40 cycles -> btn_state[1], btn_press[1] and btn_release[1] stay 0 throughout.
3. Press ch0 and hold, then raise btn_raw[0] -> btn_release[0] is a 1-cycle pulse 6 cycles after the raise, and btn_state[0] drops in the same cycle.
4. repeat_en[2]=1 and hold ch2 for 30 cycles after acceptance -> btn_press[2] pulses at +0, +10, +13, +16, ...; releasing stops further pulses.
5. Drop repeat_en[2] mid-REPEAT, then re-assert it 5 cycles later -> no pulses while low; the next pulse comes 10 cycles after re-assertion.
6. Assert reset_L=0 at debounce count 3 on ch3, then release reset with the button held -> no pulse during reset; press accepted 6 cycles after reset_L returns high.

Source files
------------

// File: rtl/pushbutton_debounce_bank_pkg.sv
// Shared types and width helpers for the pushbutton debounce bank.
package pushbutton_debounce_bank_pkg;

    typedef enum logic [1:0] {
        RPT_IDLE    = 2'd0,
        RPT_PRESSED = 2'd1,
        RPT_REPEAT  = 2'd2
    } rpt_state_e;

    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pushbutton_debounce_bank_channel.sv
// One button channel: 2-FF synchroniser, stable-time debounce, press/release pulses
// and an auto-repeat FSM that re-fires btn_press while the button is held.
module debounce_channel
    import pushbutton_debounce_bank_pkg::*;
#(
    parameter int STABLE_CYCLES = 270000,
    parameter int REPEAT_DELAY  = 13500000,
    parameter int REPEAT_PERIOD = 2700000,
    parameter bit ACTIVE_LOW    = 1'b1
) (
    input  logic clk_27,
    input  logic reset_L,
    input  logic btn_raw,
    input  logic repeat_en,
    output logic btn_state,
    output logic btn_press,
    output logic btn_release
);

    localparam int DW = cnt_width(STABLE_CYCLES);
    localparam int RW = cnt_width(max2(REPEAT_DELAY, REPEAT_PERIOD));
    localparam logic [DW-1:0] STABLE_LAST = DW'(STABLE_CYCLES - 1);
    localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);
    localparam logic RELEASED_RAW = ACTIVE_LOW;

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic [DW-1:0] deb_cnt_q, deb_cnt_d;
    logic          state_q, state_d;
    logic          press_q, press_d;
    logic          release_q, release_d;
    rpt_state_e    fsm_q, fsm_d;
    logic [RW-1:0] rpt_cnt_q, rpt_cnt_d;
    logic          pressed;
    logic          rise;
    logic          fall;

    assign pressed = (sync2_q != RELEASED_RAW);

    always_comb begin
        sync1_d   = btn_raw;
        sync2_d   = sync1_q;
        deb_cnt_d = '0;
        state_d   = state_q;
        rise      = 1'b0;
        fall      = 1'b0;
        fsm_d     = fsm_q;
        rpt_cnt_d = rpt_cnt_q;

        // Counter only runs while the synchronised level disagrees with the accepted one.
        if (pressed != state_q) begin
            if (deb_cnt_q == STABLE_LAST) begin
                state_d = ~state_q;
                rise    = ~state_q;
                fall    = state_q;
            end else begin
                deb_cnt_d = deb_cnt_q + 1'b1;
            end
        end

        press_d   = rise;
        release_d = fall;

        if (fall) begin
            fsm_d     = RPT_IDLE;
            rpt_cnt_d = '0;
        end else if (rise) begin
            fsm_d     = RPT_PRESSED;
            rpt_cnt_d = '0;
        end else begin
            case (fsm_q)
                RPT_PRESSED: begin
                    if (!repeat_en) begin
                        rpt_cnt_d = '0;
                    end else if (rpt_cnt_q == DELAY_LAST) begin
                        press_d   = 1'b1;
                        rpt_cnt_d = '0;
                        fsm_d     = RPT_REPEAT;
                    end else begin
                        rpt_cnt_d = rpt_cnt_q + 1'b1;
                    end
                end
                RPT_REPEAT: begin
                    if (!repeat_en) begin
                        rpt_cnt_d = '0;
                        fsm_d     = RPT_PRESSED;
                    end else if (rpt_cnt_q == PERIOD_LAST) begin
                        press_d   = 1'b1;
                        rpt_cnt_d = '0;
                    end else begin
                        rpt_cnt_d = rpt_cnt_q + 1'b1;
                    end
                end
                default: begin
                    fsm_d     = RPT_IDLE;
                    rpt_cnt_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_27) begin
        if (!reset_L) begin
            sync1_q   <= RELEASED_RAW;
            sync2_q   <= RELEASED_RAW;
            deb_cnt_q <= '0;
            state_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            fsm_q     <= RPT_IDLE;
            rpt_cnt_q <= '0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            deb_cnt_q <= deb_cnt_d;
            state_q   <= state_d;
            press_q   <= press_d;
            release_q <= release_d;
            fsm_q     <= fsm_d;
            rpt_cnt_q <= rpt_cnt_d;
        end
    end

    assign btn_state   = state_q;
    assign btn_press   = press_q;
    assign btn_release = release_q;

endmodule

// File: rtl/pushbutton_debounce_bank.sv
// Bank of independent debounced pushbutton channels with press/release/auto-repeat pulses.
// Outputs are registered; a clean raw change is reported 2 + STABLE_CYCLES cycles later.
module pushbutton_debounce_bank
    import pushbutton_debounce_bank_pkg::*;
#(
    parameter int NUM_BTN        = 4,
    parameter int STABLE_CYCLES  = 270000,
    parameter int REPEAT_DELAY   = 13500000,
    parameter int REPEAT_PERIOD  = 2700000,
    parameter int BTN_ACTIVE_LOW = 1
) (
    input  logic               clk_27,
    input  logic               reset_L,
    input  logic [NUM_BTN-1:0] btn_raw,
    input  logic [NUM_BTN-1:0] repeat_en,
    output logic [NUM_BTN-1:0] btn_state,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release
);

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
        debounce_channel #(
            .STABLE_CYCLES (STABLE_CYCLES),
            .REPEAT_DELAY  (REPEAT_DELAY),
            .REPEAT_PERIOD (REPEAT_PERIOD),
            .ACTIVE_LOW    (BTN_ACTIVE_LOW != 0)
        ) u_ch (
            .clk_27      (clk_27),
            .reset_L     (reset_L),
            .btn_raw     (btn_raw[i]),
            .repeat_en   (repeat_en[i]),
            .btn_state   (btn_state[i]),
            .btn_press   (btn_press[i]),
            .btn_release (btn_release[i])
        );
    end

endmodule

// File: tb/tb_pushbutton_debounce_bank.sv
// Scoreboard bench: stimulus queues expected pulse events, a forked monitor pops them on pulses.
module tb_pushbutton_debounce_bank;

    logic       clk_27 = 1'b0;
    logic       reset_L;
    logic [3:0] btn_raw;
    logic [3:0] repeat_en;
    logic [3:0] btn_state;
    logic [3:0] btn_press;
    logic [3:0] btn_release;

    typedef struct {
        int         cyc;
        logic [3:0] press;
        logic [3:0] rel;
        logic [3:0] state;
    } exp_t;

    exp_t exp_q[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    pushbutton_debounce_bank #(
        .NUM_BTN        (4),
        .STABLE_CYCLES  (4),
        .REPEAT_DELAY   (10),
        .REPEAT_PERIOD  (3),
        .BTN_ACTIVE_LOW (1)
    ) dut (
        .clk_27      (clk_27),
        .reset_L     (reset_L),
        .btn_raw     (btn_raw),
        .repeat_en   (repeat_en),
        .btn_state   (btn_state),
        .btn_press   (btn_press),
        .btn_release (btn_release)
    );

    always #5 clk_27 = ~clk_27;
    always @(posedge clk_27) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push_ev(input int c, input logic [3:0] p, input logic [3:0] r,
                           input logic [3:0] s);
        exp_t e;
        e.cyc = c; e.press = p; e.rel = r; e.state = s;
        exp_q.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk_27);
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk_27);
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk_27);
            if ((btn_press | btn_release) != 4'h0) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pulse: press=%b release=%b expected none (cycle %0d)",
                             btn_press, btn_release, cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("ev_cycle", cyc, e.cyc);
                    check("ev_press", int'(btn_press), int'(e.press));
                    check("ev_release", int'(btn_release), int'(e.rel));
                    check("ev_state", int'(btn_state), int'(e.state));
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        int t;
        int tp;
        int r;
        reset_L   = 1'b0;
        btn_raw   = 4'hF;
        repeat_en = 4'h0;
        fork
            monitor();
        join_none

        step(3);
        check("reset_state", int'(btn_state), 0);
        check("reset_press", int'(btn_press), 0);
        check("reset_release", int'(btn_release), 0);
        reset_L = 1'b1;
        step(4);
        check("idle_state", int'(btn_state), 0);

        // Clean press on ch0, then clean release.
        t = cyc;
        btn_raw[0] = 1'b0;
        push_ev(t + 6, 4'b0001, 4'b0000, 4'b0001);
        step(12);
        check("ch0_held_state", int'(btn_state), 1);
        t = cyc;
        btn_raw[0] = 1'b1;
        push_ev(t + 6, 4'b0000, 4'b0001, 4'b0000);
        step(12);

        // Bouncing ch1: 3 low, 1 high, never long enough to accept.
        for (int i = 0; i < 10; i++) begin
            btn_raw[1] = 1'b0;
            step(3);
            btn_raw[1] = 1'b1;
            step(1);
        end
        step(8);
        check("bounce_state", int'(btn_state), 0);

        // Auto-repeat on ch2, held 30 cycles after acceptance.
        repeat_en[2] = 1'b1;
        t  = cyc;
        btn_raw[2] = 1'b0;
        tp = t + 6;
        push_ev(tp, 4'b0100, 4'b0000, 4'b0100);
        for (int k = 10; k <= 34; k += 3) push_ev(tp + k, 4'b0100, 4'b0000, 4'b0100);
        push_ev(tp + 36, 4'b0000, 4'b0100, 4'b0000);
        wait_cyc(tp + 30);
        btn_raw[2] = 1'b1;
        step(12);

        // Drop repeat_en mid-REPEAT, re-assert 5 cycles later.
        t  = cyc;
        btn_raw[2] = 1'b0;
        tp = t + 6;
        push_ev(tp,      4'b0100, 4'b0000, 4'b0100);
        push_ev(tp + 10, 4'b0100, 4'b0000, 4'b0100);
        push_ev(tp + 13, 4'b0100, 4'b0000, 4'b0100);
        push_ev(tp + 29, 4'b0100, 4'b0000, 4'b0100);
        push_ev(tp + 32, 4'b0100, 4'b0000, 4'b0100);
        push_ev(tp + 35, 4'b0100, 4'b0000, 4'b0100);
        push_ev(tp + 36, 4'b0000, 4'b0100, 4'b0000);
        wait_cyc(tp + 14);
        repeat_en[2] = 1'b0;
        wait_cyc(tp + 19);
        repeat_en[2] = 1'b1;
        wait_cyc(tp + 30);
        btn_raw[2] = 1'b1;
        step(12);
        repeat_en = 4'h0;

        // Reset mid-debounce on ch3 with the button still held afterwards.
        t = cyc;
        btn_raw[3] = 1'b0;
        wait_cyc(t + 5);
        reset_L = 1'b0;
        step(3);
        check("reset_mid_state", int'(btn_state), 0);
        r = cyc;
        reset_L = 1'b1;
        push_ev(r + 6, 4'b1000, 4'b0000, 4'b1000);
        step(10);
        t = cyc;
        btn_raw[3] = 1'b1;
        push_ev(t + 6, 4'b0000, 4'b1000, 4'b0000);
        step(12);

        check("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
